// File: rtl/program_counter.sv
// rtl/program_counter.sv - registered instruction-address counter for the fetch stage
// Each edge: reset, load a jump/branch target, or step by INCR modulo 2^ADDR_W.
module program_counter #(
  parameter int unsigned            ADDR_W     = 6,
  parameter logic [ADDR_W-1:0]      RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0]      INCR       = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] AddrIn,
  output logic [ADDR_W-1:0] AddrOut
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next;

  // nReset is active-high; reset outranks a load on the same edge.
  always_comb begin
    addr_next = addr_q + INCR;
    if (nReset) begin
      addr_next = RESET_ADDR;
    end else if (WriteEnable) begin
      addr_next = AddrIn;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_next;
  end

  assign AddrOut = addr_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter
// Per-cycle comparison against an arithmetic model plus hand-computed checkpoints.
module tb_program_counter;

  localparam int ADDR_W = 6;
  localparam int MODULO = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              nReset = 1'b0;
  logic              WriteEnable = 1'b0;
  logic [ADDR_W-1:0] AddrIn = '0;
  logic [ADDR_W-1:0] AddrOut;

  int tests = 0;
  int fails = 0;

  int exp_addr = 0;
  bit model_valid = 1'b0;

  program_counter #(
    .ADDR_W(ADDR_W),
    .RESET_ADDR(6'd0),
    .INCR(6'd1)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .WriteEnable(WriteEnable),
    .AddrIn(AddrIn),
    .AddrOut(AddrOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (nReset === 1'b1) begin
      exp_addr = 0;
      model_valid = 1'b1;
    end else if (WriteEnable === 1'b1) begin
      exp_addr = int'(AddrIn);
    end else begin
      exp_addr = (exp_addr + 1) % MODULO;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      tests++;
      if (AddrOut !== ADDR_W'(exp_addr)) begin
        fails++;
        $display("FAIL model_cycle at %0t: AddrOut=%0d expected=%0d", $time, AddrOut, exp_addr);
      end
    end
  end

  task automatic check_lit(input string name, input int value);
    tests++;
    if (AddrOut !== ADDR_W'(value)) begin
      fails++;
      $display("FAIL %s: AddrOut=%0d expected=%0d", name, AddrOut, value);
    end
  endtask

  task automatic step(input logic nr, input logic we, input logic [ADDR_W-1:0] ai);
    nReset = nr;
    WriteEnable = we;
    AddrIn = ai;
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;

    step(1'b1, 1'b0, 6'd22);
    check_lit("reset_edge1", 0);
    step(1'b1, 1'b0, 6'd22);
    check_lit("reset_edge2", 0);
    step(1'b0, 1'b0, 6'd22);
    check_lit("release_1", 1);
    step(1'b0, 1'b0, 6'd22);
    check_lit("release_2", 2);
    step(1'b0, 1'b0, 6'd22);
    check_lit("release_3", 3);

    step(1'b1, 1'b0, 6'd0);
    check_lit("rerun_reset", 0);
    for (int i = 1; i <= 70; i++) begin
      step(1'b0, 1'b0, 6'(i));
      if (i == 63) check_lit("free_run_63", 63);
      if (i == 64) check_lit("wrap_to_0", 0);
    end
    check_lit("free_run_end_6", 6);

    step(1'b0, 1'b1, 6'd0);
    check_lit("load_zero", 0);
    step(1'b0, 1'b0, 6'd55);
    check_lit("ignore_addrin_1", 1);
    step(1'b0, 1'b0, 6'd55);
    check_lit("ignore_addrin_2", 2);
    step(1'b0, 1'b0, 6'd55);
    check_lit("ignore_addrin_3", 3);
    step(1'b0, 1'b0, 6'bxxxxxx);
    check_lit("ignore_addrin_x", 4);

    step(1'b0, 1'b1, 6'd26);
    check_lit("load_26", 26);
    step(1'b0, 1'b0, 6'd26);
    check_lit("after_load_27", 27);
    step(1'b0, 1'b0, 6'd26);
    check_lit("after_load_28", 28);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 6'd26);
      check_lit("hold_load_26", 26);
    end
    step(1'b0, 1'b0, 6'd26);
    check_lit("resume_27", 27);

    step(1'b1, 1'b1, 6'd40);
    check_lit("reset_over_load", 0);
    step(1'b0, 1'b1, 6'd63);
    check_lit("load_63", 63);
    step(1'b0, 1'b0, 6'd63);
    check_lit("load_63_wrap", 0);

    step(1'b0, 1'b1, 6'd8);
    step(1'b0, 1'b0, 6'd8);
    step(1'b0, 1'b0, 6'd8);
    check_lit("count_at_10", 10);
    nReset = 1'b1;
    #1;
    check_lit("reset_midcycle_no_effect", 10);
    @(posedge clk);
    #2;
    check_lit("reset_mid_operation", 0);
    step(1'b0, 1'b0, 6'd17);
    check_lit("after_mid_reset_1", 1);

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
